// File: rtl/dac_scan_pkg.sv
// dac_scan_pkg: shared constants for the DAC scan controller.
//   - default parameter values for dac_scan_ctrl
//   - FSM state encoding (3-bit constants)
//   - timer width helper sized from the longest timed interval
package dac_scan_pkg;

   localparam int NUM_LEVELS_DEF = 9;
   localparam int SETTLE_CYC_DEF = 256;
   localparam int DWELL_CYC_DEF  = 1024;
   localparam int INC_HI_DEF     = 2;
   localparam int CNT_W_DEF      = 16;
   localparam int LEVEL_W        = 4;

   typedef logic [2:0] state_t;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_DRST    = 3'd1;
   localparam logic [2:0] S_STEP_HI = 3'd2;
   localparam logic [2:0] S_STEP_LO = 3'd3;
   localparam logic [2:0] S_SETTLE  = 3'd4;
   localparam logic [2:0] S_COUNT   = 3'd5;
   localparam logic [2:0] S_REPORT  = 3'd6;
   localparam logic [2:0] S_FIN     = 3'd7;

   // Timer holds (interval - 1), so $clog2 of the longest interval suffices.
   // Floor of 2 keeps the width >= 1 and covers the 2-cycle DAC reset.
   function automatic int timer_w(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      if (m < 2) m = 2;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/dac_scan_timer.sv
// dac_scan_timer: loadable down-counter with zero flag.
//   clk, rst     : clock, async active-high reset (count -> 0)
//   load_i       : load load_val_i this cycle (wins over decrement)
//   load_val_i   : interval length minus one
//   zero_o       : count has reached zero (holds at zero)
module dac_scan_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dac_scan_ctrl.sv
// dac_scan_ctrl: steps a DAC through levels 1..NUM_LEVELS, and at each level
// waits for settling, counts hit strobes for a fixed dwell and hands the
// (level, count) result to a valid/ready consumer.
//   clk, rst          : clock, async active-high reset
//   start, abort      : one-cycle scan request / cancel
//   hit               : synchronous hit strobe, counted once per high cycle
//   rst_dac, inc_dac  : DAC step-counter reset and step strobe
//   sel_dac           : DAC readback enable (active low, low while busy)
//   busy, done        : scan in progress / one-cycle completion pulse
//   res_valid/ready   : result handshake; res_level, res_count payload
module dac_scan_ctrl
   import dac_scan_pkg::*;
#(
   parameter int NUM_LEVELS = NUM_LEVELS_DEF,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF,
   parameter int DWELL_CYC  = DWELL_CYC_DEF,
   parameter int INC_HI     = INC_HI_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic               hit,
   output logic               rst_dac,
   output logic               inc_dac,
   output logic               sel_dac,
   output logic               busy,
   output logic               done,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [LEVEL_W-1:0] res_level,
   output logic [CNT_W-1:0]   res_count
);

   localparam int TW = timer_w(SETTLE_CYC, DWELL_CYC, INC_HI);

   localparam logic [TW-1:0] LD_DRST   = TW'(1);
   localparam logic [TW-1:0] LD_STEP   = TW'(INC_HI - 1);
   localparam logic [TW-1:0] LD_SETTLE = TW'(SETTLE_CYC - 1);
   localparam logic [TW-1:0] LD_DWELL  = TW'(DWELL_CYC - 1);
   localparam logic [LEVEL_W-1:0] LAST_LVL = LEVEL_W'(NUM_LEVELS);

   state_t               state_q, state_d;
   logic [LEVEL_W-1:0]   level_q, level_d;
   logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0]     res_count_q, res_count_d;
   logic                 rst_dac_q, inc_dac_q, sel_dac_q, busy_q, done_q, res_valid_q;

   logic                 tmr_load, tmr_zero;
   logic [TW-1:0]        tmr_val;

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start && !abort) state_d = S_DRST;
         S_DRST:    if (tmr_zero) state_d = S_STEP_HI;
         S_STEP_HI: if (tmr_zero) state_d = S_STEP_LO;
         S_STEP_LO: if (tmr_zero) state_d = S_SETTLE;
         S_SETTLE:  if (tmr_zero) state_d = S_COUNT;
         S_COUNT:   if (tmr_zero) state_d = S_REPORT;
         S_REPORT:  if (res_ready) state_d = (level_q == LAST_LVL) ? S_FIN : S_STEP_HI;
         S_FIN:     state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
      // abort beats every other transition, including a same-cycle transfer
      if (abort && state_q != S_IDLE) state_d = S_IDLE;
   end

   // ---------------- interval timer ----------------
   // Loaded with (length - 1) on entry to each timed state; the state exits
   // on the cycle the timer reads zero, giving exactly 'length' cycles.
   always_comb begin
      tmr_val = '0;
      case (state_d)
         S_DRST:    tmr_val = LD_DRST;
         S_STEP_HI: tmr_val = LD_STEP;
         S_STEP_LO: tmr_val = LD_STEP;
         S_SETTLE:  tmr_val = LD_SETTLE;
         S_COUNT:   tmr_val = LD_DWELL;
         default:   tmr_val = '0;
      endcase
   end

   assign tmr_load = (state_d != state_q);

   dac_scan_timer #(.W(TW)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   // ---------------- level, hit counter, result ----------------
   always_comb begin
      level_d = level_q;
      if (state_d == S_DRST)
         level_d = '0;
      else if (state_q == S_STEP_HI && state_d == S_STEP_LO)
         level_d = level_q + LEVEL_W'(1);
   end

   always_comb begin
      hit_cnt_d = hit_cnt_q;
      if (state_d == S_COUNT && state_q != S_COUNT)
         hit_cnt_d = '0;
      else if (state_q == S_COUNT && hit && !(&hit_cnt_q))
         hit_cnt_d = hit_cnt_q + CNT_W'(1);
   end

   // Result is captured including the last dwell cycle's hit.
   always_comb begin
      res_count_d = res_count_q;
      if (state_q == S_COUNT && state_d == S_REPORT)
         res_count_d = hit_cnt_d;
   end

   // ---------------- registers ----------------
   // Outputs are decoded from state_d so they line up with state_q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         level_q     <= '0;
         hit_cnt_q   <= '0;
         res_count_q <= '0;
         rst_dac_q   <= 1'b1;
         inc_dac_q   <= 1'b0;
         sel_dac_q   <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         hit_cnt_q   <= hit_cnt_d;
         res_count_q <= res_count_d;
         rst_dac_q   <= (state_d == S_DRST);
         inc_dac_q   <= (state_d == S_STEP_HI);
         sel_dac_q   <= (state_d == S_IDLE);
         busy_q      <= (state_d != S_IDLE);
         done_q      <= (state_d == S_FIN);
         res_valid_q <= (state_d == S_REPORT);
      end
   end

   assign rst_dac   = rst_dac_q;
   assign inc_dac   = inc_dac_q;
   assign sel_dac   = sel_dac_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign res_valid = res_valid_q;
   assign res_level = level_q;
   assign res_count = res_count_q;

endmodule

// File: doc/dac_scan_ctrl.md
DAC_SCAN_CTRL -- requirements
Module: dac_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEVELS, default 9, meaning number of DAC steps per scan (levels 1..NUM_LEVELS).
REQ-002 SHALL have parameter SETTLE_CYC, default 256, meaning clk cycles waited after each step before counting.
REQ-003 SHALL have parameter DWELL_CYC, default 1024, meaning clk cycles of hit counting per level.
REQ-004 SHALL have parameter INC_HI, default 2, meaning clk cycles inc_dac is held high, then held low, per step.
REQ-005 SHALL have parameter CNT_W, default 16, meaning hit counter width.
REQ-006 clk  input  1  single clock; all logic rising-edge clk.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  one-cycle request to begin a scan.
REQ-009 abort  input  1  one-cycle request to cancel a scan.
REQ-010 hit  input  1  synchronous comparator/TDC hit strobe, one count per high cycle.
REQ-011 rst_dac  output  1  reset to DAC step counter and accumulator.
REQ-012 inc_dac  output  1  step strobe to DAC, registered, glitch-free.
REQ-013 sel_dac  output  1  DAC readback enable, active-low.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse at scan completion.
REQ-016 res_valid  output  1  result available; res_ready  input  1  consumer accepts.
REQ-017 res_level  output  4  DAC level of current result; res_count  output  CNT_W  hits counted.

Function
REQ-018 States SHALL be IDLE, DRST, STEP_HI, STEP_LO, SETTLE, COUNT, REPORT, FIN.
REQ-019 IDLE: start -> DRST; start while busy SHALL be ignored.
REQ-020 DRST: rst_dac high exactly 2 cycles, level cleared to 0, then -> STEP_HI.
REQ-021 STEP_HI: inc_dac high INC_HI cycles -> STEP_LO; level increments by 1 on entry to STEP_LO.
REQ-022 STEP_LO: inc_dac low INC_HI cycles -> SETTLE.
REQ-023 SETTLE: wait SETTLE_CYC cycles, hits ignored -> COUNT with counter cleared.
REQ-024 COUNT: counter +1 per cycle with hit high, for exactly DWELL_CYC cycles; SHALL saturate at 2^CNT_W-1, no wrap -> REPORT.
REQ-025 REPORT: res_valid high with res_level/res_count stable until res_ready sampled high; transfer on res_valid&res_ready.
REQ-026 After transfer: level == NUM_LEVELS -> FIN, else -> STEP_HI; res_valid low the cycle after transfer.
REQ-027 FIN: done high 1 cycle -> IDLE; level and last result held.
REQ-028 abort in any non-IDLE state SHALL force IDLE next cycle, inc_dac/rst_dac/res_valid low, no done pulse; abort has priority over all other transitions incl. same-cycle res_ready.
REQ-029 start and abort same cycle in IDLE: stay IDLE.
REQ-030 sel_dac SHALL be 0 while busy, 1 in IDLE.
REQ-031 All outputs SHALL be register-driven; inc_dac SHALL never pulse in DRST.
REQ-032 Timer widths SHALL be derived via $clog2 of the largest of SETTLE_CYC, DWELL_CYC, INC_HI.

Reset
REQ-033 On rst: state IDLE, rst_dac 1 (held while rst high, deasserts with it), inc_dac 0, sel_dac 1, busy 0, done 0, res_valid 0, res_level 0, res_count 0, timers 0.

Structure
REQ-034 State encoding and default parameter constants SHALL live in shared package dac_scan_pkg.
REQ-035 One sub-module dac_scan_timer (loadable down-counter with zero flag) SHALL serve STEP, SETTLE and COUNT timing; hit counter SHALL be in the top.

Verification (NUM_LEVELS=9, SETTLE_CYC=4, DWELL_CYC=8, INC_HI=2, CNT_W=4)
REQ-036 start, res_ready tied 1, hit tied 1 -> 9 results, res_level 1..9, res_count 8 each, 9 inc_dac rising edges, then done once.
REQ-037 hit tied 0 -> all res_count 0; hit high in SETTLE only -> res_count 0.
REQ-038 CNT_W=3, hit tied 1 -> res_count saturates at 7.
REQ-039 res_ready held 0 for 20 cycles in REPORT level 3 -> res_valid, res_level 3, res_count stable throughout; no inc_dac.
REQ-040 abort during COUNT of level 5 -> IDLE next cycle, no done, sel_dac 1; new start -> DRST, first result level 1.
REQ-041 rst asserted mid-SETTLE -> all outputs at reset values immediately (asynchronous), rst_dac high.
